data_mem_responder: RTL and testbench
=====================================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory slave; responds to load/store requests issued by the processor MEM stage.
- Latches each request, inserts WAIT_CYCLES wait states, then commits the store or returns sign-extended load data with a one-cycle response pulse.
- Asserts Busy so the pipeline freezes MEM and earlier stages while a transaction is outstanding.
- Supports word, halfword and byte accesses, little-endian, on a word-organised array.

Parameters:
DEPTH, 1024, number of 32-bit words in the array (power of 2)
WAIT_CYCLES, 2, wait states between acceptance and response (0..15)

Ports:
Clk  input  1  clock; all state updates on the rising edge
Reset  input  1  asynchronous, active-low reset
ReqValid  input  1  request present this cycle
ReqWrite  input  1  1 = store, 0 = load
ReqAddress  input  32  byte address
ReqWriteData  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
ReqLoadStore  input  2  access size: 00 word, 01 halfword, 10 byte, 11 reserved
Busy  output  1  transaction outstanding; requester must stall
RespValid  output  1  one-cycle pulse: transaction complete
RespReadData  output  32  load result, valid with RespValid
RespError  output  1  misaligned or reserved-size access, valid with RespValid

Behaviour:
- Reset low (asynchronous): state = IDLE; Busy = 0, RespValid = 0, RespReadData = 0, RespError = 0; wait counter = 0.
- Reset does not clear the memory array.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On ReqValid = 1 at a rising edge: latch write, address, data and size.
  - Load the counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES > 0, else go to RESP.
- WAIT: decrement the counter each cycle; when it reaches 1, go to RESP on the next edge.
- RESP (exactly one cycle):
  - RespValid = 1.
  - A store writes the array at the end of this cycle.
  - A load drives RespReadData.
  - Next state is IDLE.
- Busy = 1 in WAIT and RESP, 0 in IDLE.
- Total latency: acceptance edge to the RespValid cycle is WAIT_CYCLES + 1 cycles.
- Back-to-back: a ReqValid high in the RESP cycle is ignored. The next request is accepted only in IDLE, so throughput is one transaction per WAIT_CYCLES + 2 cycles.
- ReqValid while Busy = 1 is ignored; inputs are not sampled after latching.
- Addressing:
  - Word index = latched address [log2(DEPTH)+1:2].
  - Upper address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
  - Byte lane = address[1:0], little-endian (lane 0 = bits [7:0]).
- Store:
  - Word writes all 4 lanes.
  - Halfword writes lanes {a1,0}, {a1,1} with data [15:0].
  - Byte writes a single lane with data [7:0].
  - Lanes not selected are unchanged.
- Load:
  - Word returns the full word.
  - Halfword returns the selected half, sign-extended to 32 bits.
  - Byte returns the selected byte, sign-extended to 32 bits.
- Error conditions: word with address[1:0] != 00, halfword with address[0] = 1, or size 11.
  - RespError = 1 and RespReadData = 0.
  - A store with an error performs no write.
  - Latency is unchanged.
- RespReadData and RespError hold their last values after RESP until the next RESP or reset. They are meaningful only when RespValid = 1.
- Reset asserted in WAIT or RESP (before the write edge) aborts the transaction: no write, no RespValid, return to IDLE.
- The array is initialised to all zeros at time 0 (simulation initial state).

Test Plan:
- Word round trip, WAIT_CYCLES = 2: store 0xDEADBEEF to 0x10; load 0x10. RespValid rises 3 cycles after each acceptance; load returns 0xDEADBEEF, RespError = 0.
- Byte/half lanes: store word 0x00000000 to 0x20; store byte 0x80 to 0x21; store half 0x7FFF to 0x22. Load word 0x20 gives 0x7FFF8000; load byte 0x21 gives 0xFFFFFF80; load half 0x22 gives 0x00007FFF.
- Misalignment: word store to 0x31 gives RespError = 1, then a word load from 0x30 is unchanged. Half load at 0x23 gives RespError = 1, RespReadData = 0. Size 11 gives RespError = 1.
- Busy/ignore: assert ReqValid continuously with changing addresses. Only requests sampled in IDLE are served (every 4 cycles at WAIT_CYCLES = 2); Busy high for 3 cycles per transaction.
- Reset mid-operation: store 0x12345678 to 0x40; pull Reset low during WAIT. Busy = 0 and RespValid = 0 immediately; a later load of 0x40 returns the prior value (0).
- Wrap and zero wait: DEPTH = 1024, WAIT_CYCLES = 0. Store 0xA5A5A5A5 to 0x1000, then load 0x0. Response arrives 1 cycle after acceptance and returns 0xA5A5A5A5.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the MEM stage (master) and the data-memory responder (slave).
interface data_mem_responder_if;
  logic        ReqValid;
  logic        ReqWrite;
  logic [31:0] ReqAddress;
  logic [31:0] ReqWriteData;
  logic [1:0]  ReqLoadStore;
  logic        Busy;
  logic        RespValid;
  logic [31:0] RespReadData;
  logic        RespError;

  modport master (
    output ReqValid, ReqWrite, ReqAddress, ReqWriteData, ReqLoadStore,
    input  Busy, RespValid, RespReadData, RespError
  );

  modport slave (
    input  ReqValid, ReqWrite, ReqAddress, ReqWriteData, ReqLoadStore,
    output Busy, RespValid, RespReadData, RespError
  );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle word-organised data memory: latches one request, waits WAIT_CYCLES,
// then commits a store or returns sign-extended load data with a one-cycle response.
module data_mem_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  data_mem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 2;
  localparam int unsigned CW = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [LW-1:0]   addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [1:0]      size_q, size_d;
  logic            busy_q, busy_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rerr_q, rerr_d;

  logic [31:0]     mem_q [DEPTH] = '{default: '0};

  logic [AW-1:0]   rd_idx_c, wr_idx_c;
  logic [31:0]     rd_word_c, wr_word_c;
  logic            rd_err_c, wr_err_c;
  logic            unused_addr_c;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
    return (size == 2'b11) || ((size == 2'b00) && (lane != 2'b00)) ||
           ((size == 2'b01) && lane[0]);
  endfunction

  function automatic logic [31:0] load_of(input logic [31:0] word, input logic [1:0] size,
                                          input logic [1:0] lane);
    logic [15:0] h;
    logic [7:0]  b;
    h = word[{lane[1], 4'b0000} +: 16];
    b = word[{lane, 3'b000} +: 8];
    case (size)
      2'b00:   return word;
      2'b01:   return {{16{h[15]}}, h};
      2'b10:   return {{24{b[7]}}, b};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] merge_of(input logic [31:0] word, input logic [31:0] wdata,
                                           input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = word;
    case (size)
      2'b00:   m = wdata;
      2'b01:   m[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      2'b10:   m[{lane, 3'b000} +: 8] = wdata[7:0];
      default: m = word;
    endcase
    return m;
  endfunction

  // Upper address bits alias onto the array, so they are deliberately dropped.
  assign unused_addr_c = ^bus.ReqAddress[31:LW];

  // Read side decodes the request about to enter RESP (it may be latched this same edge).
  assign rd_idx_c  = addr_d[AW+1:2];
  assign rd_word_c = mem_q[rd_idx_c];
  assign rd_err_c  = access_err(size_d, addr_d[1:0]);
  assign wr_idx_c  = addr_q[AW+1:2];
  assign wr_word_c = mem_q[wr_idx_c];
  assign wr_err_c  = access_err(size_q, addr_q[1:0]);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      size_q   <= '0;
      busy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      size_q   <= size_d;
      busy_q   <= busy_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rerr_q   <= rerr_d;
    end
  end

  // Store commits on the edge that leaves RESP; an async reset beforehand leaves state IDLE.
  always_ff @(posedge Clk) begin
    if ((state_q == S_RESP) && wr_q && !wr_err_c) begin
      mem_q[wr_idx_c] <= merge_of(wr_word_c, wdata_q, size_q, addr_q[1:0]);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    size_d   = size_q;
    busy_d   = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = rdata_q;
    rerr_d   = rerr_q;

    case (state_q)
      S_IDLE: begin
        if (bus.ReqValid) begin
          wr_d    = bus.ReqWrite;
          addr_d  = bus.ReqAddress[LW-1:0];
          wdata_d = bus.ReqWriteData;
          size_d  = bus.ReqLoadStore;
          cnt_d   = CW'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    if ((state_d == S_RESP) && (state_q != S_RESP)) begin
      rvalid_d = 1'b1;
      rerr_d   = rd_err_c;
      rdata_d  = (rd_err_c || wr_d) ? 32'h0 : load_of(rd_word_c, size_d, addr_d[1:0]);
    end
  end

  assign bus.Busy         = busy_q;
  assign bus.RespValid    = rvalid_q;
  assign bus.RespReadData = rdata_q;
  assign bus.RespError    = rerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: u0 at WAIT_CYCLES=2, u1 at WAIT_CYCLES=0.
module tb_data_mem_responder;

  logic Clk = 1'b0;
  logic Reset;
  always #5 Clk = ~Clk;

  data_mem_responder_if b0 ();
  data_mem_responder_if b1 ();

  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u0 (.Clk(Clk), .Reset(Reset), .bus(b0.slave));
  data_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u1 (.Clk(Clk), .Reset(Reset), .bus(b1.slave));

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        chk_data;
  } exp_t;

  exp_t        sbq[$];
  bit   [31:0] m0 [1024];
  bit   [31:0] m1 [1024];
  int          n_chk = 0;
  int          n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Reference memory: applies a store and yields the expected response.
  task automatic model(input bit sel, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz, output exp_t e);
    bit [31:0] w;
    bit [15:0] h;
    bit [7:0]  b;
    bit [9:0]  idx;
    idx = addr[11:2];
    w   = sel ? m1[idx] : m0[idx];
    e.err = (sz == 2'b11) || (sz == 2'b00 && addr[1:0] != 2'b00) || (sz == 2'b01 && addr[0]);
    e.chk_data = !wr;
    e.data = 32'h0;
    if (!e.err) begin
      if (wr) begin
        case (sz)
          2'b00: w = wd;
          2'b01: if (addr[1]) w[31:16] = wd[15:0]; else w[15:0] = wd[15:0];
          default: case (addr[1:0])
            2'd0: w[7:0]   = wd[7:0];
            2'd1: w[15:8]  = wd[7:0];
            2'd2: w[23:16] = wd[7:0];
            default: w[31:24] = wd[7:0];
          endcase
        endcase
        if (sel) m1[idx] = w; else m0[idx] = w;
      end else begin
        h = addr[1] ? w[31:16] : w[15:0];
        b = 8'(w >> (8 * addr[1:0]));
        case (sz)
          2'b00:   e.data = w;
          2'b01:   e.data = {{16{h[15]}}, h};
          default: e.data = {{24{b[7]}}, b};
        endcase
      end
    end
  endtask

  task automatic drive(input bit sel, input bit v, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [1:0] sz);
    if (sel) begin
      b1.ReqValid = v; b1.ReqWrite = wr; b1.ReqAddress = addr;
      b1.ReqWriteData = wd; b1.ReqLoadStore = sz;
    end else begin
      b0.ReqValid = v; b0.ReqWrite = wr; b0.ReqAddress = addr;
      b0.ReqWriteData = wd; b0.ReqLoadStore = sz;
    end
  endtask

  function automatic logic rv_of(input bit sel);
    return sel ? b1.RespValid : b0.RespValid;
  endfunction

  // One transaction starting at a negedge with the DUT idle; ends at a negedge, idle again.
  task automatic txn(input bit sel, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [1:0] sz, input string tag);
    exp_t e;
    int   lat;
    model(sel, wr, addr, wd, sz, e);
    sbq.push_back(e);
    drive(sel, 1'b1, wr, addr, wd, sz);
    @(posedge Clk);
    #1;
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    lat = 0;
    while (lat < 20) begin
      @(negedge Clk);
      lat++;
      if (rv_of(sel)) break;
    end
    check({tag, "_resp_seen"}, 32'(rv_of(sel)), 32'd1);
    if (rv_of(sel)) begin
      e = sbq.pop_front();
      check({tag, "_latency"}, 32'(lat), sel ? 32'd1 : 32'd3);
      check({tag, "_busy"}, 32'(sel ? b1.Busy : b0.Busy), 32'd1);
      check({tag, "_err"}, 32'(sel ? b1.RespError : b0.RespError), 32'(e.err));
      if (e.chk_data) check({tag, "_data"}, sel ? b1.RespReadData : b0.RespReadData, e.data);
      @(negedge Clk);
      check({tag, "_pulse_end"}, 32'(rv_of(sel)), 32'd0);
      check({tag, "_idle"}, 32'(sel ? b1.Busy : b0.Busy), 32'd0);
    end else begin
      void'(sbq.pop_front());
    end
  endtask

  initial begin
    exp_t e;
    Reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    #1;
    check("rst_busy", 32'(b0.Busy), 32'd0);
    check("rst_rvalid", 32'(b0.RespValid), 32'd0);
    check("rst_rdata", b0.RespReadData, 32'h0);
    check("rst_err", 32'(b0.RespError), 32'd0);
    check("rst_busy1", 32'(b1.Busy), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    txn(0, 1, 32'h10, 32'hDEADBEEF, 2'b00, "st_word");
    txn(0, 0, 32'h10, 32'h0,        2'b00, "ld_word");

    txn(0, 1, 32'h20, 32'h00000000, 2'b00, "st_w20");
    txn(0, 1, 32'h21, 32'h00000080, 2'b10, "st_b21");
    txn(0, 1, 32'h22, 32'h00007FFF, 2'b01, "st_h22");
    txn(0, 0, 32'h20, 32'h0, 2'b00, "ld_w20");
    txn(0, 0, 32'h21, 32'h0, 2'b10, "ld_b21");
    txn(0, 0, 32'h22, 32'h0, 2'b01, "ld_h22");
    txn(0, 0, 32'h23, 32'h0, 2'b10, "ld_b23");

    txn(0, 1, 32'h31, 32'hFFFFFFFF, 2'b00, "st_mis31");
    txn(0, 0, 32'h30, 32'h0, 2'b00, "ld_w30");
    txn(0, 0, 32'h23, 32'h0, 2'b01, "ld_hmis23");
    txn(0, 0, 32'h20, 32'h0, 2'b11, "ld_size11");
    txn(0, 1, 32'h20, 32'h12345678, 2'b11, "st_size11");
    txn(0, 0, 32'h20, 32'h0, 2'b00, "ld_w20_again");

    // Abort a store with reset while it sits in WAIT.
    txn(0, 0, 32'h10, 32'h0, 2'b00, "ld_pre_rst");
    drive(0, 1'b1, 1'b1, 32'h40, 32'h12345678, 2'b00);
    @(posedge Clk);
    #1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    @(negedge Clk);
    check("mid_busy", 32'(b0.Busy), 32'd1);
    Reset = 1'b0;
    #1;
    check("abort_busy", 32'(b0.Busy), 32'd0);
    check("abort_rvalid", 32'(b0.RespValid), 32'd0);
    check("abort_rdata", b0.RespReadData, 32'h0);
    @(negedge Clk);
    Reset = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      check("abort_no_resp", 32'(b0.RespValid), 32'd0);
    end
    txn(0, 0, 32'h40, 32'h0, 2'b00, "ld_w40");

    // Continuous ReqValid: only requests seen in IDLE are served.
    txn(0, 1, 32'h50, 32'h11223344, 2'b00, "st_w50");
    for (int i = 0; i < 16; i++) begin
      check("bb_busy", 32'(b0.Busy), 32'((i % 4) != 0));
      check("bb_rvalid", 32'(b0.RespValid), 32'((i % 4) == 3));
      if (b0.RespValid) begin
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          check("bb_data", b0.RespReadData, e.data);
          check("bb_err", 32'(b0.RespError), 32'(e.err));
        end else begin
          check("bb_unexpected_resp", 32'd1, 32'(sbq.size()));
        end
      end
      if ((i % 4) == 0) begin
        model(0, 1'b0, 32'h10 + 32'(i) * 32'h10, 32'h0, 2'b00, e);
        sbq.push_back(e);
      end
      drive(0, 1'b1, 1'b0, 32'h10 + 32'(i) * 32'h10, 32'h0, 2'b00);
      @(negedge Clk);
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    check("bb_queue_empty", 32'(sbq.size()), 32'd0);
    sbq.delete();
    check("bb_idle", 32'(b0.Busy), 32'd0);

    // Zero wait states and address wrap on u1.
    txn(1, 1, 32'h1000, 32'hA5A5A5A5, 2'b00, "z_st_wrap");
    txn(1, 0, 32'h0,    32'h0,        2'b00, "z_ld_wrap");
    txn(1, 0, 32'h1003, 32'h0,        2'b10, "z_ld_b3");
    txn(1, 0, 32'h2, 32'h0, 2'b01, "z_ld_h2");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
